// File: rtl/rmii_transmitter_if.sv
// Byte-stream handshake and RMII transmit pins of one transmitter instance.
interface rmii_transmitter_if;
    logic [8:0] transmit_data;
    logic       transmit_data_enable;
    logic       transmit_data_ready;
    logic [1:0] rmii_transmit_data;
    logic       rmii_transmit_data_valid;
    logic       transmit_busy;
    logic       transmit_underrun;

    // Upstream byte source (and pin observer).
    modport master (
        output transmit_data,
        output transmit_data_enable,
        input  transmit_data_ready,
        input  rmii_transmit_data,
        input  rmii_transmit_data_valid,
        input  transmit_busy,
        input  transmit_underrun
    );

    // The transmitter itself.
    modport slave (
        input  transmit_data,
        input  transmit_data_enable,
        output transmit_data_ready,
        output rmii_transmit_data,
        output rmii_transmit_data_valid,
        output transmit_busy,
        output transmit_underrun
    );
endinterface

// File: rtl/rmii_transmitter.sv
// RMII transmit path: frames a 9-bit byte stream as preamble/SFD/payload/pad/FCS dibits
// and enforces the interframe gap.
module rmii_transmitter #(
    parameter int unsigned PREAMBLE_BYTES       = 7,
    parameter int unsigned MINIMUM_FRAME_BYTES  = 60,
    parameter int unsigned INTERFRAME_GAP_BYTES = 12,
    parameter bit          APPEND_FCS           = 1'b1
) (
    input logic             clock,
    input logic             reset_n,
    rmii_transmitter_if.slave tx_if
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StPreamble = 3'd1;
    localparam logic [2:0] StSfd      = 3'd2;
    localparam logic [2:0] StPayload  = 3'd3;
    localparam logic [2:0] StPad      = 3'd4;
    localparam logic [2:0] StFcs      = 3'd5;
    localparam logic [2:0] StGap      = 3'd6;

    localparam logic [7:0]  PreLast = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0]  GapLast = 8'(INTERFRAME_GAP_BYTES - 1);
    localparam logic [15:0] MinLen  = 16'(MINIMUM_FRAME_BYTES);
    localparam logic [2:0]  GapTarget  = (INTERFRAME_GAP_BYTES == 0) ? StIdle : StGap;
    localparam logic [2:0]  BodyTarget = APPEND_FCS ? StFcs : GapTarget;

    logic [2:0]  state_q, state_d;
    logic [1:0]  dibit_q, dibit_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  data_q, data_d;
    logic        last_q, last_d;
    logic [31:0] crc_q, crc_d;
    logic        underrun_q, underrun_d;
    logic        alive_q;

    logic        ready, handshake, byte_end, tx_en;
    logic [7:0]  cur_byte;
    logic [31:0] fcs_word;
    logic [15:0] len_inc;

    // Reflected CRC-32 (0xEDB88320) folded over one byte.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] din);
        logic [31:0] c;
        c = crc ^ {24'h0, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign byte_end  = (dibit_q == 2'd3);
    assign len_inc   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    assign fcs_word  = ~crc_q;
    assign tx_en     = (state_q == StPreamble) || (state_q == StSfd) || (state_q == StPayload) ||
                       (state_q == StPad) || (state_q == StFcs);
    // alive_q keeps ready low while reset is asserted even though the state is IDLE.
    assign ready     = alive_q && ((state_q == StIdle) ||
                                   ((state_q == StPayload) && !last_q && byte_end));
    assign handshake = ready && tx_if.transmit_data_enable;

    // Byte currently on the wire, chosen by state.
    always_comb begin
        cur_byte = 8'h00;
        unique case (state_q)
            StPreamble: cur_byte = 8'h55;
            StSfd:      cur_byte = 8'hD5;
            StPayload:  cur_byte = data_q;
            StFcs:      cur_byte = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
            default:    cur_byte = 8'h00;
        endcase
    end

    assign tx_if.transmit_data_ready      = ready;
    assign tx_if.rmii_transmit_data       = tx_en ? cur_byte[{dibit_q, 1'b0} +: 2] : 2'b00;
    assign tx_if.rmii_transmit_data_valid = tx_en;
    assign tx_if.transmit_busy            = (state_q != StIdle);
    assign tx_if.transmit_underrun        = underrun_q;

    // Next-state logic; every transition outside IDLE happens on the last dibit of a byte.
    always_comb begin
        state_d    = state_q;
        dibit_d    = (state_q == StIdle) ? 2'd0 : dibit_q + 2'd1;
        cnt_d      = cnt_q;
        len_d      = len_q;
        data_d     = data_q;
        last_d     = last_q;
        crc_d      = crc_q;
        underrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    data_d  = tx_if.transmit_data[7:0];
                    last_d  = tx_if.transmit_data[8];
                    crc_d   = 32'hFFFFFFFF;
                    len_d   = 16'd0;
                    cnt_d   = 8'd0;
                    state_d = (PREAMBLE_BYTES == 0) ? StSfd : StPreamble;
                end
            end
            StPreamble: begin
                if (byte_end) begin
                    if (cnt_q == PreLast) begin
                        cnt_d   = 8'd0;
                        state_d = StSfd;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StSfd: begin
                if (byte_end) state_d = StPayload;
            end
            StPayload: begin
                if (byte_end) begin
                    crc_d = crc32_byte(crc_q, data_q);
                    len_d = len_inc;
                    if (last_q) begin
                        state_d = (len_inc < MinLen) ? StPad : BodyTarget;
                    end else if (handshake) begin
                        data_d = tx_if.transmit_data[7:0];
                        last_d = tx_if.transmit_data[8];
                    end else begin
                        // Upstream starved us: cut the frame short, no FCS.
                        state_d    = GapTarget;
                        underrun_d = 1'b1;
                    end
                end
            end
            StPad: begin
                if (byte_end) begin
                    crc_d = crc32_byte(crc_q, 8'h00);
                    len_d = len_inc;
                    if (len_inc >= MinLen) state_d = BodyTarget;
                end
            end
            StFcs: begin
                if (byte_end) begin
                    if (cnt_q == 8'd3) begin
                        cnt_d   = 8'd0;
                        state_d = GapTarget;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StGap: begin
                if (byte_end) begin
                    if (cnt_q == GapLast) begin
                        cnt_d   = 8'd0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            dibit_q    <= 2'd0;
            cnt_q      <= 8'd0;
            len_q      <= 16'd0;
            data_q     <= 8'h00;
            last_q     <= 1'b0;
            crc_q      <= 32'hFFFFFFFF;
            underrun_q <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dibit_q    <= dibit_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            data_q     <= data_d;
            last_q     <= last_d;
            crc_q      <= crc_d;
            underrun_q <= underrun_d;
            alive_q    <= 1'b1;
        end
    end

endmodule
